// File: rtl/countdown_timer_4b.sv
// Loadable down-counter/timer: counts a stored value down to zero and emits a
// one-cycle done pulse, then either stops (one-shot) or reloads (periodic).
module countdown_timer_4b #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] start_val_s;

  // A load on the same edge as start/terminal count wins over the stored value.
  always_comb begin
    if (load) begin
      start_val_s = load_value;
    end else begin
      start_val_s = reload_q;
    end
  end

  // Reload register: captured by load unless abort discards the whole edge.
  always_comb begin
    reload_d = reload_q;
    if (!abort && load) begin
      reload_d = load_value;
    end else begin
      reload_d = reload_q;
    end
  end

  // Next-state and count logic with abort > start > load > pause > decrement.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      count_d = ZERO;
    end else if (start) begin
      if (start_val_s != ZERO) begin
        state_d = ST_RUN;
        count_d = start_val_s;
      end else begin
        // Zero-length timer completes on the start edge itself.
        state_d = ST_IDLE;
        count_d = ZERO;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            count_d = load_value;
          end else begin
            count_d = count_q;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else begin
            done_d = 1'b1;
            if (AUTO_RELOAD && (start_val_s != ZERO)) begin
              count_d = start_val_s;
            end else begin
              state_d = ST_IDLE;
              count_d = ZERO;
            end
          end
        end
        ST_HOLD: begin
          // Resume costs one edge: count is left alone on the way back to RUN.
          if (!pause) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = ZERO;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, count, reload and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer_4b.sv
// Bench for countdown_timer_4b: one-shot and periodic instances driven in
// parallel, compared every cycle against a behavioural timer model.
module tb_countdown_timer_4b;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;
  logic         abort;
  logic [W-1:0] count0, count1;
  logic         busy0, busy1, done0, done1;

  int n_total = 0;
  int n_bad   = 0;

  // Model state per instance: index 0 one-shot, index 1 periodic.
  int m_cnt [2];
  int m_rld [2];
  bit m_run [2];
  bit m_hold[2];
  bit m_done[2];

  always #5 clk = ~clk;

  countdown_timer_4b #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_oneshot (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .abort(abort),
    .count(count0), .busy(busy0), .done(done0)
  );

  countdown_timer_4b #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_periodic (
    .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .abort(abort),
    .count(count1), .busy(busy1), .done(done1)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_rld[i]  = 0;
      m_run[i]  = 1'b0;
      m_hold[i] = 1'b0;
      m_done[i] = 1'b0;
    end
  endtask

  // One clock edge of the timer as described behaviourally.
  task automatic model_step();
    int v;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        v = load ? int'(load_value) : m_rld[i];
        m_done[i] = 1'b0;
        if (abort) begin
          m_run[i]  = 1'b0;
          m_hold[i] = 1'b0;
          m_cnt[i]  = 0;
        end else if (start) begin
          m_hold[i] = 1'b0;
          if (v > 0) begin
            m_cnt[i] = v;
            m_run[i] = 1'b1;
          end else begin
            m_cnt[i]  = 0;
            m_run[i]  = 1'b0;
            m_done[i] = 1'b1;
          end
        end else if (!m_run[i]) begin
          if (load) m_cnt[i] = int'(load_value);
        end else if (m_hold[i]) begin
          if (!pause) m_hold[i] = 1'b0;
        end else if (pause) begin
          m_hold[i] = 1'b1;
        end else if (m_cnt[i] > 1) begin
          m_cnt[i] = m_cnt[i] - 1;
        end else begin
          m_done[i] = 1'b1;
          if (i == 1 && v > 0) begin
            m_cnt[i] = v;
          end else begin
            m_cnt[i] = 0;
            m_run[i] = 1'b0;
          end
        end
        if (!abort && load) m_rld[i] = int'(load_value);
      end
    end
  endtask

  task automatic check_all(input string ph);
    check_val({ph, " count[oneshot]"},  int'(count0), m_cnt[0]);
    check_val({ph, " busy[oneshot]"},   int'(busy0),  int'(m_run[0]));
    check_val({ph, " done[oneshot]"},   int'(done0),  int'(m_done[0]));
    check_val({ph, " count[periodic]"}, int'(count1), m_cnt[1]);
    check_val({ph, " busy[periodic]"},  int'(busy1),  int'(m_run[1]));
    check_val({ph, " done[periodic]"},  int'(done1),  int'(m_done[1]));
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_all(ph);
  endtask

  task automatic drive(input string ph, input bit ld, input int lv,
                       input bit st, input bit ps, input bit ab);
    load       = ld;
    load_value = lv[W-1:0];
    start      = st;
    pause      = ps;
    abort      = ab;
    tick(ph);
  endtask

  task automatic idle(input string ph, input int n);
    repeat (n) drive(ph, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    load_value = '0;
    start      = 1'b0;
    pause      = 1'b0;
    abort      = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic one-shot run of 5; periodic twin keeps cycling.
    drive("load5", 1'b1, 5, 1'b0, 1'b0, 1'b0);
    drive("start5", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle("run5", 7);
    drive("abort", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Period 3, then load of 2 mid-run.
    drive("load3", 1'b1, 3, 1'b1, 1'b0, 1'b0);
    idle("per3", 7);
    drive("load2mid", 1'b1, 2, 1'b0, 1'b0, 1'b0);
    idle("per2", 8);
    drive("abort", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Pause for 4 cycles once count reaches 4.
    drive("start6", 1'b1, 6, 1'b1, 1'b0, 1'b0);
    idle("to4", 2);
    repeat (4) drive("pause", 1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle("resume", 8);

    // Zero-length timer.
    drive("load0", 1'b1, 0, 1'b0, 1'b0, 1'b1);
    drive("load0b", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    drive("start0", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle("after0", 2);

    // Restart at count 2, then abort at count 3.
    drive("load7", 1'b1, 7, 1'b1, 1'b0, 1'b0);
    idle("to2", 5);
    drive("restart", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle("to3", 4);
    drive("abort3", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle("postabort", 2);

    // Asynchronous reset between edges at count 9.
    drive("start15", 1'b1, 15, 1'b1, 1'b0, 1'b0);
    idle("to9", 6);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    drive("start_after_rst", 1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle("after_rst", 2);

    // Simultaneous events.
    drive("ld4start", 1'b1, 4, 1'b1, 1'b0, 1'b0);
    idle("run4", 6);
    drive("abort_start", 1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle("post_as", 2);
    drive("period1", 1'b1, 1, 1'b1, 1'b0, 1'b0);
    idle("per1", 4);

    // Randomised traffic.
    for (int k = 0; k < 800; k++) begin
      drive("rand",
            ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
